axi_reg_slice_fifo_chnl: RTL and testbench

AXI_REG_SLICE_FIFO_CHNL -- requirements
Module: axi_reg_slice_fifo_chnl

---
 rtl/axi_reg_slice_fifo_chnl_if.sv | 28 ++
 rtl/axi_reg_slice_fifo_chnl.sv | 131 +++++++++++++
 tb/tb_axi_reg_slice_fifo_chnl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/axi_reg_slice_fifo_chnl_if.sv
// Handshake channel bundle for axi_reg_slice_fifo_chnl.
// Member names are from the slice's point of view: _i enter it, _o leave it.
interface axi_reg_slice_fifo_chnl_if #(
    parameter int unsigned PLD_W = 1,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             valid_i;
    logic             ready_o;
    logic [PLD_W-1:0] payload_i;
    logic             valid_o;
    logic             ready_i;
    logic [PLD_W-1:0] payload_o;
    logic             flush_i;
    logic [CNT_W-1:0] level_o;
    logic [CNT_W-1:0] peak_o;

    modport slave (
        input  valid_i, payload_i, ready_i, flush_i,
        output ready_o, valid_o, payload_o, level_o, peak_o
    );

    modport master (
        output valid_i, payload_i, ready_i, flush_i,
        input  ready_o, valid_o, payload_o, level_o, peak_o
    );
endinterface

// File: rtl/axi_reg_slice_fifo_chnl.sv
// Valid/ready register slice backed by a small FIFO, with level and high-water reporting.
// TMO=0 gives flop-sourced outputs; TMO=1 lets a beat fall through while the FIFO is empty.
module axi_reg_slice_fifo_chnl #(
    parameter int unsigned TMO   = 0,
    parameter int unsigned PLD_W = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         aclk,
    input  logic                         areset,
    axi_reg_slice_fifo_chnl_if.slave     chnl
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(DEPTH);

    if (TMO > 1) begin : g_bad_tmo
        $error("axi_reg_slice_fifo_chnl: TMO must be 0 or 1");
    end
    if (PLD_W < 1 || PLD_W > 1024) begin : g_bad_pld_w
        $error("axi_reg_slice_fifo_chnl: PLD_W must be 1..1024");
    end
    if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
        $error("axi_reg_slice_fifo_chnl: DEPTH must be 2..64");
    end

    logic [PLD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] peak_q, peak_d;
    logic [PLD_W-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;

    logic             bypass_c;
    logic             ready_c;
    logic             valid_c;
    logic             push_c;
    logic             pop_c;
    logic             store_c;
    logic             deq_c;
    logic             mem_we_c;

    // Fall-through is only possible in TMO=1 with nothing queued ahead of the beat.
    assign bypass_c = (TMO == 1) && (level_q == '0);
    assign ready_c  = ready_q & ~areset;
    assign valid_c  = bypass_c ? chnl.valid_i : valid_q;
    assign push_c   = chnl.valid_i & ready_c;
    assign pop_c    = valid_c & chnl.ready_i;
    assign store_c  = push_c & ~(bypass_c & pop_c);
    assign deq_c    = pop_c & ~bypass_c;

    assign chnl.ready_o   = ready_c;
    assign chnl.valid_o   = valid_c;
    assign chnl.payload_o = bypass_c ? (chnl.valid_i ? chnl.payload_i : '0) : head_q;
    assign chnl.level_o   = level_q;
    assign chnl.peak_o    = peak_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        peak_d   = peak_q;
        head_d   = head_q;
        valid_d  = valid_q;
        ready_d  = ready_q;
        mem_we_c = 1'b0;

        if (chnl.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            peak_d   = '0;
            head_d   = '0;
            valid_d  = 1'b0;
            ready_d  = 1'b1;
        end else begin
            if (store_c) begin
                mem_we_c = 1'b1;
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (deq_c) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({store_c, deq_c})
                2'b10:   level_d = level_q + CNT_W'(1);
                2'b01:   level_d = level_q - CNT_W'(1);
                default: level_d = level_q;
            endcase
            peak_d  = (level_d > peak_q) ? level_d : peak_q;
            valid_d = (level_d != '0);
            ready_d = (level_d < LVL_FULL);
            // Next head is the beat being written this cycle when it lands in the head slot.
            if (level_d == '0) begin
                head_d = '0;
            end else if (store_c && (wr_ptr_q == rd_ptr_d)) begin
                head_d = chnl.payload_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            peak_q   <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            peak_q   <= peak_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge aclk) begin
        if (mem_we_c) begin
            mem_q[wr_ptr_q] <= chnl.payload_i;
        end
    end
endmodule

// File: tb/tb_axi_reg_slice_fifo_chnl.sv
// Directed bench for axi_reg_slice_fifo_chnl: one TMO=0 and one TMO=1 instance, PLD_W=8, DEPTH=4.
module tb_axi_reg_slice_fifo_chnl;
    logic aclk;
    logic areset;
    int   nvec;
    int   nerr;

    axi_reg_slice_fifo_chnl_if #(.PLD_W(8), .DEPTH(4)) i0 ();
    axi_reg_slice_fifo_chnl_if #(.PLD_W(8), .DEPTH(4)) i1 ();

    axi_reg_slice_fifo_chnl #(.TMO(0), .PLD_W(8), .DEPTH(4)) u_dut0 (
        .aclk   (aclk),
        .areset (areset),
        .chnl   (i0)
    );

    axi_reg_slice_fifo_chnl #(.TMO(1), .PLD_W(8), .DEPTH(4)) u_dut1 (
        .aclk   (aclk),
        .areset (areset),
        .chnl   (i1)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic st0(input string tag, input int lvl, input int pk,
                       input logic rdy, input logic vld, input int pld);
        chk({tag, " level0"},   32'(i0.level_o),   32'(lvl));
        chk({tag, " peak0"},    32'(i0.peak_o),    32'(pk));
        chk({tag, " ready0"},   32'(i0.ready_o),   32'(rdy));
        chk({tag, " valid0"},   32'(i0.valid_o),   32'(vld));
        chk({tag, " payload0"}, 32'(i0.payload_o), 32'(pld));
    endtask

    task automatic st1(input string tag, input int lvl, input int pk,
                       input logic rdy, input logic vld, input int pld);
        chk({tag, " level1"},   32'(i1.level_o),   32'(lvl));
        chk({tag, " peak1"},    32'(i1.peak_o),    32'(pk));
        chk({tag, " ready1"},   32'(i1.ready_o),   32'(rdy));
        chk({tag, " valid1"},   32'(i1.valid_o),   32'(vld));
        chk({tag, " payload1"}, 32'(i1.payload_o), 32'(pld));
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        areset       = 1'b1;
        i0.valid_i   = 1'b0;
        i0.payload_i = 8'h00;
        i0.ready_i   = 1'b0;
        i0.flush_i   = 1'b0;
        i1.valid_i   = 1'b0;
        i1.payload_i = 8'h00;
        i1.ready_i   = 1'b0;
        i1.flush_i   = 1'b0;

        // Reset: ready low while held, clean state after release.
        tick();
        chk("rst_hold ready0", 32'(i0.ready_o), 32'(0));
        chk("rst_hold ready1", 32'(i1.ready_o), 32'(0));
        areset = 1'b0;
        #1;
        st0("rst", 0, 0, 1'b1, 1'b0, 0);
        st1("rst", 0, 0, 1'b1, 1'b0, 0);

        // Fill to full with downstream stalled.
        i0.ready_i = 1'b0;
        i0.valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i0.payload_i = 8'((k + 1) * 8'h11);
            tick();
            st0($sformatf("fill%0d", k), k + 1, k + 1, (k < 3), 1'b1, 8'h11);
        end
        i0.payload_i = 8'h99;
        tick();
        st0("full_hold", 4, 4, 1'b0, 1'b1, 8'h11);

        // Drain from full while 0x55 waits for ready.
        i0.ready_i   = 1'b1;
        i0.payload_i = 8'h55;
        tick();
        st0("pop11", 3, 4, 1'b1, 1'b1, 8'h22);
        tick();
        st0("push55", 3, 4, 1'b1, 1'b1, 8'h33);
        i0.valid_i = 1'b0;
        tick();
        st0("pop33", 2, 4, 1'b1, 1'b1, 8'h44);
        tick();
        st0("pop44", 1, 4, 1'b1, 1'b1, 8'h55);
        tick();
        st0("pop55", 0, 4, 1'b1, 1'b0, 0);

        // Streaming at one beat per cycle, pointers wrap.
        i0.valid_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i0.payload_i = 8'(8'h60 + k);
            tick();
            st0($sformatf("stream%0d", k), 1, 4, 1'b1, 1'b1, 8'h60 + k);
        end
        i0.valid_i = 1'b0;
        tick();
        st0("stream_drain", 0, 4, 1'b1, 1'b0, 0);

        // Flush at level 3 with a coincident push.
        i0.ready_i = 1'b0;
        i0.valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i0.payload_i = 8'(k + 1);
            tick();
        end
        st0("lvl3", 3, 4, 1'b1, 1'b1, 8'h01);
        i0.flush_i   = 1'b1;
        i0.payload_i = 8'h77;
        tick();
        st0("flush", 0, 0, 1'b1, 1'b0, 0);
        i0.flush_i = 1'b0;
        i0.valid_i = 1'b0;
        i0.ready_i = 1'b1;
        tick();
        st0("post_flush", 0, 0, 1'b1, 1'b0, 0);

        // Reset mid-transfer at level 2.
        i0.ready_i   = 1'b0;
        i0.valid_i   = 1'b1;
        i0.payload_i = 8'hAA;
        tick();
        i0.payload_i = 8'hBB;
        tick();
        st0("lvl2", 2, 2, 1'b1, 1'b1, 8'hAA);
        i0.valid_i = 1'b0;
        areset     = 1'b1;
        #1;
        chk("mid_rst ready0", 32'(i0.ready_o), 32'(0));
        tick();
        areset = 1'b0;
        #1;
        st0("mid_rst", 0, 0, 1'b1, 1'b0, 0);
        i0.valid_i   = 1'b1;
        i0.payload_i = 8'hCC;
        tick();
        st0("first_after_rst", 1, 1, 1'b1, 1'b1, 8'hCC);
        i0.valid_i = 1'b0;
        i0.ready_i = 1'b1;
        tick();
        st0("drain_cc", 0, 1, 1'b1, 1'b0, 0);

        // TMO=1 fall-through while empty.
        i1.ready_i   = 1'b1;
        i1.valid_i   = 1'b1;
        i1.payload_i = 8'hA5;
        #1;
        st1("bypass_comb", 0, 0, 1'b1, 1'b1, 8'hA5);
        tick();
        st1("bypass_edge", 0, 0, 1'b1, 1'b1, 8'hA5);
        i1.valid_i = 1'b0;
        #1;
        st1("bypass_idle", 0, 0, 1'b1, 1'b0, 0);

        // TMO=1 with downstream stalled: beats are stored and replayed in order.
        i1.ready_i   = 1'b0;
        i1.valid_i   = 1'b1;
        i1.payload_i = 8'hB1;
        #1;
        st1("offer_b1", 0, 0, 1'b1, 1'b1, 8'hB1);
        tick();
        st1("store_b1", 1, 1, 1'b1, 1'b1, 8'hB1);
        i1.payload_i = 8'hB2;
        tick();
        st1("store_b2", 2, 2, 1'b1, 1'b1, 8'hB1);
        i1.valid_i = 1'b0;
        i1.ready_i = 1'b1;
        tick();
        st1("pop_b1", 1, 2, 1'b1, 1'b1, 8'hB2);
        tick();
        st1("pop_b2", 0, 2, 1'b1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
